mdu_seq_ctrl: RTL and testbench



---
 rtl/mdu_seq_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_mdu_seq_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/mdu_seq_ctrl.sv
// RV32M multi-cycle sequencer: iterative shift-add multiply and restoring divide with flush abort.
// Optional MDU_FAST_MUL_EN replaces the iterative multiply with a single-cycle 33x33 signed multiplier.
module mdu_seq_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MUL  = 3'd1,
    DIV  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t          state;
  logic [2:0]      funct3_r;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] b_mag;
  logic [XLEN-1:0] quo, rem;
  logic [CW-1:0]   cnt;

  logic            sgn1, sgn2, in_a_neg, in_b_neg, div_zero, ovf;
  logic [XLEN-1:0] in_a_mag, in_b_mag, special_res, min_neg, fix_res, mul_word;
  logic [XLEN-1:0] quo_fix, rem_fix;
  logic [XLEN+1:0] trial;

  // Operand signedness per funct3: rs1 signed for mulh/mulhsu/div/rem, rs2 for mulh/div/rem
  always_comb begin
    sgn1 = 1'b0;
    sgn2 = 1'b0;
    case (funct3_i)
      3'b001:  begin sgn1 = 1'b1; sgn2 = 1'b1; end
      3'b010:  begin sgn1 = 1'b1; sgn2 = 1'b0; end
      3'b100:  begin sgn1 = 1'b1; sgn2 = 1'b1; end
      3'b110:  begin sgn1 = 1'b1; sgn2 = 1'b1; end
      default: begin sgn1 = 1'b0; sgn2 = 1'b0; end
    endcase
  end

  assign min_neg  = {1'b1, {(XLEN-1){1'b0}}};
  assign in_a_neg = sgn1 & rs1_i[XLEN-1];
  assign in_b_neg = sgn2 & rs2_i[XLEN-1];
  assign in_a_mag = in_a_neg ? -rs1_i : rs1_i;
  assign in_b_mag = in_b_neg ? -rs2_i : rs2_i;
  assign div_zero = funct3_i[2] & (rs2_i == {XLEN{1'b0}});
  assign ovf      = funct3_i[2] & ~funct3_i[0] & (rs1_i == min_neg) & (rs2_i == {XLEN{1'b1}});
  // Divide-by-zero: all-ones quotient, dividend as remainder; overflow: min_neg quotient, zero remainder
  assign special_res = div_zero ? (funct3_i[1] ? rs1_i : {XLEN{1'b1}})
                                : (funct3_i[1] ? {XLEN{1'b0}} : min_neg);

  // Restoring step: shift next dividend bit into the remainder and trial-subtract the divisor
  assign trial   = {1'b0, rem, quo[XLEN-1]} - {2'b00, b_mag};
  assign quo_fix = (a_neg ^ b_neg) ? -quo : quo;
  assign rem_fix = a_neg ? -rem : rem;
  assign fix_res = funct3_r[2] ? (funct3_r[1] ? rem_fix : quo_fix) : mul_word;

`ifdef MDU_FAST_MUL_EN
  logic signed [XLEN:0]     fast_a, fast_b;
  logic signed [2*XLEN+1:0] fast_p;
  logic [XLEN-1:0]          fast_res;
  logic [2:0]               unused_fast;

  assign fast_a      = {sgn1 & rs1_i[XLEN-1], rs1_i};
  assign fast_b      = {sgn2 & rs2_i[XLEN-1], rs2_i};
  assign fast_p      = fast_a * fast_b;
  assign fast_res    = (funct3_i[1:0] == 2'b00) ? fast_p[XLEN-1:0] : fast_p[2*XLEN-1:XLEN];
  assign mul_word    = {XLEN{1'b0}};
  assign unused_fast = {fast_p[2*XLEN+1:2*XLEN], funct3_r[0]};
`else
  logic [XLEN-1:0]   a_mag;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN:0]     psum;

  // Shift-add step: add multiplicand into the upper half when the current multiplier bit is set
  assign psum     = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, a_mag} : {(XLEN+1){1'b0}});
  assign prod_fix = (a_neg ^ b_neg) ? -prod : prod;
  assign mul_word = (funct3_r[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
`endif

  assign busy_o = (state == MUL) || (state == DIV) || (state == FIX);
  assign done_o = (state == DONE);

  // Sequencer state, datapath registers and registered result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      funct3_r <= 3'b000;
      a_neg    <= 1'b0;
      b_neg    <= 1'b0;
      b_mag    <= {XLEN{1'b0}};
      quo      <= {XLEN{1'b0}};
      rem      <= {XLEN{1'b0}};
      cnt      <= {CW{1'b0}};
      result_o <= {XLEN{1'b0}};
`ifndef MDU_FAST_MUL_EN
      a_mag    <= {XLEN{1'b0}};
      prod     <= {(2*XLEN){1'b0}};
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start_i && !flush_i) begin
            funct3_r <= funct3_i;
            a_neg    <= in_a_neg;
            b_neg    <= in_b_neg;
            b_mag    <= in_b_mag;
            quo      <= in_a_mag;
            rem      <= {XLEN{1'b0}};
            cnt      <= {CW{1'b0}};
`ifndef MDU_FAST_MUL_EN
            a_mag    <= in_a_mag;
            prod     <= {{XLEN{1'b0}}, in_b_mag};
`endif
            if (div_zero || ovf) begin
              result_o <= special_res;
              state    <= DONE;
            end else if (!funct3_i[2]) begin
`ifdef MDU_FAST_MUL_EN
              result_o <= fast_res;
              state    <= DONE;
`else
              state    <= MUL;
`endif
            end else begin
              state <= DIV;
            end
          end else begin
            state <= IDLE;
          end
        end
`ifndef MDU_FAST_MUL_EN
        MUL: begin
          if (flush_i) begin
            state <= IDLE;
          end else begin
            prod <= {psum, prod[XLEN-1:1]};
            cnt  <= cnt + {{(CW-1){1'b0}}, 1'b1};
            if (cnt == CW'(XLEN-1)) begin
              state <= FIX;
            end else begin
              state <= MUL;
            end
          end
        end
`endif
        DIV: begin
          if (flush_i) begin
            state <= IDLE;
          end else begin
            if (trial[XLEN+1]) begin
              rem <= {rem[XLEN-2:0], quo[XLEN-1]};
              quo <= {quo[XLEN-2:0], 1'b0};
            end else begin
              rem <= trial[XLEN-1:0];
              quo <= {quo[XLEN-2:0], 1'b1};
            end
            cnt <= cnt + {{(CW-1){1'b0}}, 1'b1};
            if (cnt == CW'(XLEN-1)) begin
              state <= FIX;
            end else begin
              state <= DIV;
            end
          end
        end
        FIX: begin
          if (flush_i) begin
            state <= IDLE;
          end else begin
            result_o <= fix_res;
            state    <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_seq_ctrl.sv
// Scoreboard bench for mdu_seq_ctrl: stimulus pushes expected results, a negedge monitor checks each done_o.
module tb_mdu_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic [2:0]  funct3_i = 3'b000;
  logic [31:0] rs1_i = 32'h0;
  logic [31:0] rs2_i = 32'h0;
  logic        flush_i = 1'b0;
  logic        busy_o, done_o;
  logic [31:0] result_o;

  mdu_seq_ctrl #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .funct3_i(funct3_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .flush_i(flush_i),
    .busy_o(busy_o), .done_o(done_o), .result_o(result_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    int          due;
    int          busy;
  } exp_t;

  exp_t q[$];
  exp_t mon_x;
  int   checks = 0;
  int   failures = 0;
  int   cycle = 0;
  int   busy_cnt = 0;

`ifdef MDU_FAST_MUL_EN
  localparam int MUL_LAT = 1;
  localparam int MUL_BSY = 0;
`else
  localparam int MUL_LAT = 34;
  localparam int MUL_BSY = 33;
`endif

  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Monitor: count busy cycles and score every done pulse against the queue
  always @(negedge clk) begin
    if (busy_o) begin
      busy_cnt++;
    end else if (done_o) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_done: done_o=1 with no outstanding op (cycle %0d)", cycle);
      end else begin
        mon_x = q.pop_front();
        chk("result", result_o, mon_x.res);
        chk("done_cycle", cycle, mon_x.due);
        chk("busy_cycles", busy_cnt, mon_x.busy);
      end
      busy_cnt = 0;
    end else begin
      busy_cnt = 0;
    end
  end

  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] e, input int lat, input int bsy, input int hold);
    exp_t x;
    int   n;
    @(negedge clk); #1;
    start_i = 1'b1; funct3_i = f; rs1_i = a; rs2_i = b;
    x.res = e; x.due = cycle + lat; x.busy = bsy;
    q.push_back(x);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk); #1;
      rs1_i = ~a; rs2_i = ~b; funct3_i = ~f;
    end
    @(negedge clk); #1;
    start_i = 1'b0;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL timeout: no done_o for funct3=%0d within 100 cycles", f);
      q.delete();
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    chk("reset_busy", {31'b0, busy_o}, 32'h0);
    chk("reset_done", {31'b0, done_o}, 32'h0);
    chk("reset_result", result_o, 32'h0);

    run_op(3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT, MUL_BSY, 0);
    run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT, MUL_BSY, 0);
    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT, MUL_BSY, 0);
    run_op(3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, MUL_LAT, MUL_BSY, 0);
    run_op(3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 34, 33, 0);
    run_op(3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 34, 33, 0);
    run_op(3'b101, 32'd100, 32'd7, 32'd14, 34, 33, 0);
    run_op(3'b111, 32'd100, 32'd7, 32'd2, 34, 33, 0);
    run_op(3'b100, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34, 33, 0);
    run_op(3'b110, 32'd7, 32'hFFFF_FFFE, 32'd1, 34, 33, 0);
    run_op(3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0, 0);
    run_op(3'b110, 32'd5, 32'd0, 32'd5, 1, 0, 0);
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0, 0);
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1, 0, 0);
    // start held (with changing operands) while busy must not re-sample
    run_op(3'b101, 32'd100, 32'd7, 32'd14, 34, 33, 10);

    // flush mid-divide: busy drops, no done, result keeps 14
    @(negedge clk); #1;
    start_i = 1'b1; funct3_i = 3'b101; rs1_i = 32'd1000; rs2_i = 32'd3;
    @(negedge clk); #1;
    start_i = 1'b0;
    repeat (9) @(negedge clk);
    #1;
    chk("busy_before_flush", {31'b0, busy_o}, 32'h1);
    flush_i = 1'b1;
    @(negedge clk); #1;
    flush_i = 1'b0;
    chk("busy_after_flush", {31'b0, busy_o}, 32'h0);
    chk("result_after_flush", result_o, 32'd14);
    repeat (40) @(negedge clk);
    #1;
    chk("result_flush_held", result_o, 32'd14);

    // flush and start together in IDLE: start dropped
    start_i = 1'b1; flush_i = 1'b1; funct3_i = 3'b101; rs1_i = 32'd5; rs2_i = 32'd0;
    @(negedge clk); #1;
    start_i = 1'b0; flush_i = 1'b0;
    chk("flush_start_busy", {31'b0, busy_o}, 32'h0);
    chk("flush_start_done", {31'b0, done_o}, 32'h0);
    repeat (5) @(negedge clk);

    // reset in the middle of a multiply
    #1;
    start_i = 1'b1; funct3_i = 3'b011; rs1_i = 32'd3; rs2_i = 32'd5;
    @(negedge clk); #1;
    start_i = 1'b0;
    repeat (4) @(negedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk); #1;
    rst_n = 1'b1;
    chk("midreset_busy", {31'b0, busy_o}, 32'h0);
    chk("midreset_done", {31'b0, done_o}, 32'h0);
    chk("midreset_result", result_o, 32'h0);
    repeat (40) @(negedge clk);

    run_op(3'b000, 32'd6, 32'd7, 32'd42, MUL_LAT, MUL_BSY, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
